// File: rtl/assoc_cache_controller.sv
// assoc_cache_controller: 2-way set-associative, write-through, no-write-allocate cache in front of an SRAM controller.
// Optional load hit/miss statistics are enabled by defining ASSOC_CACHE_STATS_EN.
module assoc_cache_controller #(
  parameter int SET_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        sram_read_en,
  output logic        sram_write_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 29 - SET_BITS;
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
  state_t state_q, state_d;
  logic [1:0][SETS-1:0] valid_q, valid_d;
  logic [SETS-1:0] lru_q, lru_d;
  logic [TAG_W-1:0] tag_q [2][SETS];
  logic [31:0] data_q [2][SETS][2];
  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic wsel, hit0, hit1, hit_way, victim, fill_en, upd_en;
  logic [31:0] hit_word, sram_word;
  logic unused_addr;
  assign idx = address[2+SET_BITS:3];
  assign tag = address[31:3+SET_BITS];
  assign wsel = address[2];
  assign unused_addr = &{1'b0, address[1:0]};
  assign hit0 = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1 = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit = hit0 | hit1;
  assign hit_way = !hit0;
  assign hit_word = data_q[hit_way][idx][wsel];
  assign sram_word = wsel ? sram_read_data[63:32] : sram_read_data[31:0];
  // Fill empty ways first, way0 preferred, before evicting the LRU way.
  assign victim = !valid_q[0][idx] ? 1'b0 : !valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign sram_address = address;
  assign sram_write_data = write_data;
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    lru_d = lru_q;
    ready = 1'b0;
    read_data = 32'd0;
    sram_read_en = 1'b0;
    sram_write_en = 1'b0;
    fill_en = 1'b0;
    upd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_W_EN) begin
          sram_write_en = 1'b1;
          state_d = WR_THRU;
        end else if (MEM_R_EN && hit) begin
          ready = 1'b1;
          read_data = hit_word;
          lru_d[idx] = ~hit_way;
        end else if (MEM_R_EN) begin
          sram_read_en = 1'b1;
          state_d = RD_MISS;
        end else begin
          ready = 1'b1;
        end
      end
      RD_MISS: begin
        sram_read_en = 1'b1;
        if (sram_ready) begin
          ready = 1'b1;
          read_data = sram_word;
          fill_en = 1'b1;
          valid_d[victim][idx] = 1'b1;
          lru_d[idx] = ~victim;
          state_d = IDLE;
        end
      end
      WR_THRU: begin
        sram_write_en = 1'b1;
        if (sram_ready) begin
          ready = 1'b1;
          upd_en = hit;
          lru_d[idx] = hit ? ~hit_way : lru_q[idx];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      lru_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      lru_q <= lru_d;
    end
  end
  always_ff @(posedge clk) begin
    if (fill_en && !rst) begin
      tag_q[victim][idx] <= tag;
      data_q[victim][idx][1'b0] <= sram_read_data[31:0];
      data_q[victim][idx][1'b1] <= sram_read_data[63:32];
    end
    if (upd_en && !rst)
      data_q[hit_way][idx][wsel] <= write_data;
  end
`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic hit_inc, miss_inc;
  assign hit_inc = (state_q == IDLE) && MEM_R_EN && !MEM_W_EN && hit;
  assign miss_inc = (state_q == RD_MISS) && sram_ready;
  always_comb begin
    hit_count_d = (hit_inc && !(&hit_count_q)) ? hit_count_q + 32'd1 : hit_count_q;
    miss_count_d = (miss_inc && !(&miss_count_q)) ? miss_count_q + 32'd1 : miss_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end
  assign hit_count = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count = 32'd0;
  assign miss_count = 32'd0;
`endif
endmodule

// File: tb/tb_assoc_cache_controller.sv
// tb_assoc_cache_controller: directed scoreboard bench; an SRAM responder answers after three enabled cycles.
module tb_assoc_cache_controller;
  logic clk = 1'b0, rst = 1'b1, mr = 1'b0, mw = 1'b0, sram_ready = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [63:0] sram_read_data = '0;
  logic ready, hit, sram_read_en, sram_write_en;
  logic [31:0] read_data, sram_address, sram_write_data, hit_count, miss_count;
  typedef struct {logic ld; logic [31:0] data; logic hit; int waits;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, wcnt = 0, rcnt = 0;
  logic [63:0] mem [logic [28:0]];
  assoc_cache_controller #(.SET_BITS(6)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(mr), .MEM_W_EN(mw), .address(addr), .write_data(wdata),
    .ready(ready), .read_data(read_data), .hit(hit), .sram_read_en(sram_read_en),
    .sram_write_en(sram_write_en), .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data), .sram_ready(sram_ready), .hit_count(hit_count), .miss_count(miss_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  // SRAM responder: pulses sram_ready on the third consecutive enabled cycle.
  initial forever begin
    @(posedge clk);
    #2;
    sram_ready = 1'b0;
    if (sram_read_en || sram_write_en) begin
      rcnt++;
      if (rcnt == 3) begin
        rcnt = 0;
        sram_ready = 1'b1;
        sram_read_data = mem.exists(sram_address[31:3]) ? mem[sram_address[31:3]] : 64'd0;
        if (sram_write_en) begin
          if (sram_address[2]) mem[sram_address[31:3]] = {sram_write_data, sram_read_data[31:0]};
          else mem[sram_address[31:3]] = {sram_read_data[63:32], sram_write_data};
        end
      end
    end else rcnt = 0;
  end
  always @(negedge clk) begin
    exp_t e;
    if (rst) wcnt = 0;
    else if (mr || mw) begin
      if (!ready) begin
        check("pending_sram_en", {30'd0, sram_read_en, sram_write_en}, mw ? 32'd1 : 32'd2);
        wcnt++;
      end else if (q.size() == 0) begin
        check("unexpected_completion", 32'd1, 32'd0);
        wcnt = 0;
      end else begin
        e = q.pop_front();
        check("latency", wcnt, e.waits);
        check("hit_at_done", {31'd0, hit}, {31'd0, e.hit});
        if (e.ld) check("read_data", read_data, e.data);
        wcnt = 0;
      end
    end
  end
  task automatic issue(input logic ld, input logic both, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_hit, input int exp_wait);
    int n;
    q.push_back('{ld, exp_d, exp_hit, exp_wait});
    addr = a; wdata = wd; mr = ld | both; mw = !ld;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (n == 20) check("timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    mr = 1'b0; mw = 1'b0;
  endtask
  task automatic check_stats(input logic [31:0] h, input logic [31:0] m);
`ifdef ASSOC_CACHE_STATS_EN
    check("hit_count", hit_count, h);
    check("miss_count", miss_count, m);
`else
    check("hit_count", hit_count, 32'd0);
    check("miss_count", miss_count, 32'd0);
    if (h > m + 32'd100) $display("stats disabled");
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    mem[29'h20] = 64'hBBBBBBBB_AAAAAAAA;
    mem[29'h60] = 64'h33000004_33000000;
    mem[29'hA0] = 64'h55000004_55000000;
    mem[29'h120] = 64'h99000004_99000000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_sram_en", {30'd0, sram_read_en, sram_write_en}, 32'd0);
    check_stats(32'd0, 32'd0);
    @(posedge clk);
    #1;
    issue(1, 0, 32'h100, 0, 32'hAAAAAAAA, 0, 2);
    issue(1, 0, 32'h104, 0, 32'hBBBBBBBB, 1, 0);
    check_stats(32'd1, 32'd1);
    issue(0, 0, 32'h104, 32'h12345678, 0, 1, 2);
    issue(1, 0, 32'h104, 0, 32'h12345678, 1, 0);
    issue(1, 0, 32'h300, 0, 32'h33000000, 0, 2);
    issue(1, 0, 32'h500, 0, 32'h55000000, 0, 2);
    issue(1, 0, 32'h300, 0, 32'h33000000, 1, 0);
    issue(1, 0, 32'h100, 0, 32'hAAAAAAAA, 0, 2);
    issue(1, 0, 32'h104, 0, 32'h12345678, 1, 0);
    issue(0, 1, 32'h900, 32'hDEADBEEF, 0, 0, 2);
    issue(1, 0, 32'h900, 0, 32'hDEADBEEF, 0, 2);
    check_stats(32'd4, 32'd5);
    addr = 32'h500; mr = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; mr = 1'b0;
    @(negedge clk);
    check("abort_sram_en", {30'd0, sram_read_en, sram_write_en}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_hit", {31'd0, hit}, 32'd0);
    @(posedge clk);
    #1;
    issue(1, 0, 32'h100, 0, 32'hAAAAAAAA, 0, 2);
    check_stats(32'd0, 32'd1);
    check("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
